// File: rtl/soc_run_pkg.sv
// Shared definitions for the SoC run controller.
//   run_state_e : FSM state codes, also driven on the state output
//   PASS_CODE   : mailbox value that ends a run with PASS
//   is_terminal : true for the states that end a run
package soc_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_PASS    = 3'd3,
    S_FAIL    = 3'd4,
    S_TIMEOUT = 3'd5,
    S_TRAP    = 3'd6
  } run_state_e;

  localparam logic [31:0] PASS_CODE = 32'h1;

  function automatic logic is_terminal(input run_state_e s);
    return s inside {S_PASS, S_FAIL, S_TIMEOUT, S_TRAP};
  endfunction

endpackage

// File: rtl/soc_run_sat_cnt.sv
// Saturating up-counter. It clears synchronously, counts while en is high,
// and sticks at all-ones.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear, wins over en
//   en       : count enable
//   q        : count value
module soc_run_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 q <= '0;
    else if (clr)            q <= '0;
    else if (en && q != '1)  q <= q + CNT_W'(1);
  end

endmodule

// File: rtl/soc_run_ctrl.sv
// SoC run controller. It holds the core in reset, releases it, and watches
// the bus for a result-mailbox write. It also watches the trap inputs and an
// optional cycle budget, then latches the outcome.
//   clk, rst        : clock, async active-high reset
//   start           : one-cycle run request (ignored in RESET/RUN)
//   trap            : per-hart trap flags
//   mem_*           : snooped SoC bus handshake and write fields
//   core_rst        : reset to the core, low only in RUN
//   state           : current FSM state code
//   done, pass      : run finished / finished with PASS
//   result          : latched mailbox value
//   trap_vec        : latched trap flags
//   cycle_count     : RUN cycles elapsed
// When SOC_RUN_CTRL_CYCLE_CNT_EN is defined, the build includes the RUN cycle
// counter and the timeout. Without it, cycle_count is tied to 0 and TIMEOUT
// cannot be reached.
module soc_run_ctrl
  import soc_run_pkg::*;
#(
  parameter int          RST_CYCLES     = 5,
  parameter int          TIMEOUT_CYCLES = 200,
  parameter int          NUM_HARTS      = 1,
  parameter logic [31:0] MAILBOX_ADDR   = 32'h1000_0000,
  parameter int          CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HARTS-1:0] trap,
  input  logic                 mem_valid,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 core_rst,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          result,
  output logic [NUM_HARTS-1:0] trap_vec,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int             RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]  RST_LAST = RW'(RST_CYCLES - 1);
  localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

  run_state_e    st, st_nxt;
  logic [RW-1:0] rcnt;
  logic          mb_wr, timeout_hit;
  logic          clr, ld_res, ld_trap;

  // A mailbox write is a full-word completed transfer to the mailbox address.
  assign mb_wr = mem_valid & mem_ready & (mem_wstrb == 4'hF) & (mem_addr == MAILBOX_ADDR);

`ifdef SOC_RUN_CTRL_CYCLE_CNT_EN
  localparam logic [CNT_W:0] TO_VAL = (CNT_W+1)'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;

  soc_run_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (st == S_RUN),
    .q   (cnt_q)
  );
  assign cycle_count = cnt_q;
  // Compare against the value the counter takes this cycle. The exiting cycle
  // is then counted, and cycle_count equals the budget in TIMEOUT.
  assign timeout_hit = TO_EN && (({1'b0, cnt_q} + (CNT_W+1)'(1)) == TO_VAL);
`else
  assign cycle_count = '0;
  assign timeout_hit = 1'b0 & TO_EN;
`endif

  // rcnt is zero on the first RESET cycle because it clears outside RESET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               rcnt <= '0;
    else if (st != S_RESET) rcnt <= '0;
    else                   rcnt <= rcnt + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt  = st;
    clr     = 1'b0;
    ld_res  = 1'b0;
    ld_trap = 1'b0;
    case (st)
      S_IDLE:  if (start) begin st_nxt = S_RESET; clr = 1'b1; end
      S_RESET: if (rcnt == RST_LAST) st_nxt = S_RUN;
      S_RUN: begin
        // Priority: trap, then mailbox, then budget.
        if (|trap) begin
          st_nxt  = S_TRAP;
          ld_trap = 1'b1;
        end else if (mb_wr && mem_wdata != '0) begin
          st_nxt = (mem_wdata == PASS_CODE) ? S_PASS : S_FAIL;
          ld_res = 1'b1;
        end else if (timeout_hit) begin
          st_nxt = S_TIMEOUT;
        end
      end
      default: if (start) begin st_nxt = S_RESET; clr = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      trap_vec <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      if (clr)         result <= '0;
      else if (ld_res) result <= mem_wdata;
      if (clr)          trap_vec <= '0;
      else if (ld_trap) trap_vec <= trap;
      done     <= is_terminal(st_nxt);
      pass     <= (st_nxt == S_PASS);
      core_rst <= (st_nxt != S_RUN);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Testbench for soc_run_ctrl: directed scenarios and a randomized run, checked
// each cycle against a behavioural model of the run sequence.
module tb_soc_run_ctrl;
  localparam int          RSTC = 5;
  localparam int          TO   = 200;
  localparam int          NH   = 2;
  localparam int          CW   = 32;
  localparam logic [31:0] MB   = 32'h1000_0000;
`ifdef SOC_RUN_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, mem_valid, mem_ready;
  logic [NH-1:0] trap;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        core_rst, done, pass;
  logic [2:0]  state;
  logic [31:0] result;
  logic [NH-1:0] trap_vec;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  soc_run_ctrl #(.RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO), .NUM_HARTS(NH),
                 .MAILBOX_ADDR(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .trap(trap),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .core_rst(core_rst),
    .state(state), .done(done), .pass(pass), .result(result),
    .trap_vec(trap_vec), .cycle_count(cycle_count));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the run. Codes: 0 idle, 1 reset, 2 run,
  // 3 pass, 4 fail, 5 timeout, 6 trap.
  logic [2:0]    m_st;
  int            m_rc;
  logic [31:0]   m_runs, m_res;
  logic [NH-1:0] m_tv;
  logic          m_mb;
  assign m_mb = mem_valid && mem_ready && mem_wstrb == 4'hF && mem_addr == MB;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 3'd0; m_rc <= 0; m_runs <= '0; m_res <= '0; m_tv <= '0;
    end else begin
      case (m_st)
        3'd1: begin
          m_rc <= m_rc + 1;
          if (m_rc + 1 == RSTC) m_st <= 3'd2;
        end
        3'd2: begin
          m_runs <= m_runs + 1;
          if (trap != 0) begin
            m_st <= 3'd6; m_tv <= trap;
          end else if (m_mb && mem_wdata != 0) begin
            m_res <= mem_wdata;
            m_st  <= (mem_wdata == 32'h1) ? 3'd3 : 3'd4;
          end else if (CNT_EN && TO != 0 && m_runs + 1 == TO) begin
            m_st <= 3'd5;
          end
        end
        default: if (start) begin
          m_st <= 3'd1; m_rc <= 0; m_runs <= '0; m_res <= '0; m_tv <= '0;
        end
      endcase
    end
  end

  // Compare all outputs against the model on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("cycle",
            {state, done, pass, core_rst, result, trap_vec, cycle_count},
            {m_st, (m_st >= 3'd3), (m_st == 3'd3), (m_st != 3'd2), m_res, m_tv,
             (CNT_EN ? m_runs : 32'd0)});
    end
  end

  task automatic idle_bus();
    start = 0; trap = '0; mem_valid = 0; mem_ready = 0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1; mem_ready = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
  endtask

  // Request a run and return at the negedge of the first RUN cycle.
  task automatic go_run();
    int k;
    start = 1; @(negedge clk); start = 0;
    k = 0;
    while (state !== 3'd2 && k < 20) begin @(negedge clk); k++; end
    check("reach_run", state, 3'd2);
  endtask

  initial begin
    int k;
    rst = 1; idle_bus();
    repeat (3) @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_outs", {core_rst, done, pass, result, trap_vec, cycle_count},
          {1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0});
    rst = 0;
    @(negedge clk);

    // PASS on the 50th RUN cycle.
    go_run();
    repeat (49) @(negedge clk);
    wr(MB, 32'h1, 4'hF);
    @(negedge clk); idle_bus();
    check("pass_state", state, 3'd3);
    check("pass_flags", {done, pass, core_rst}, 3'b111);
    check("pass_result", result, 32'h1);
    check("pass_cnt", cycle_count, CNT_EN ? 32'd50 : 32'd0);

    // No activity: TIMEOUT after the budget, or still running without the counter.
    go_run();
    k = 0;
    while (state === 3'd2 && k < 300) begin @(negedge clk); k++; end
    check("to_len", k, CNT_EN ? 200 : 300);
    check("to_state", state, CNT_EN ? 3'd5 : 3'd2);
    check("to_flags", {done, pass}, CNT_EN ? 2'b10 : 2'b00);
    check("to_cnt", cycle_count, CNT_EN ? 32'd200 : 32'd0);

    // A trap beats a PASS write in the same cycle.
    if (state !== 3'd2) go_run();
    trap = 2'b10; wr(MB, 32'h1, 4'hF);
    @(negedge clk); idle_bus();
    check("trap_state", state, 3'd6);
    check("trap_vec", trap_vec, 2'b10);
    check("trap_result", result, 32'd0);

    // A partial-strobe write is ignored, and the full write that follows gives FAIL.
    go_run();
    wr(MB, 32'hDEAD, 4'h3);
    @(negedge clk);
    check("partial_ign", state, 3'd2);
    wr(MB, 32'hDEAD, 4'hF);
    @(negedge clk); idle_bus();
    check("fail_state", state, 3'd4);
    check("fail_result", result, 32'hDEAD);

    // Asynchronous reset mid-run, then RESET lasts RSTC cycles.
    go_run();
    repeat (10) @(negedge clk);
    @(posedge clk); #2 rst = 1; #1;
    check("arst_state", state, 3'd0);
    check("arst_outs", {core_rst, done, pass, cycle_count}, {1'b1, 1'b0, 1'b0, 32'd0});
    #1 rst = 0;
    @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    k = 0;
    while (state === 3'd1 && k < 20) begin k++; @(negedge clk); end
    check("reset_len", k, RSTC);
    check("reset_exit", state, 3'd2);

    // Randomized traffic: a dense phase, then a sparse one that reaches timeouts.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < (ph == 0 ? 2000 : 3000); i++) begin
        start     = (ph == 0) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 299) == 0);
        trap      = ($urandom_range(0, 199) == 0) ? NH'($urandom) : '0;
        mem_valid = (ph == 0) ? $urandom_range(0, 1) : ($urandom_range(0, 99) == 0);
        mem_ready = $urandom_range(0, 3) != 0;
        mem_addr  = $urandom_range(0, 1) ? MB : (MB + 32'($urandom_range(0, 3) * 4));
        mem_wstrb = $urandom_range(0, 3) != 0 ? 4'hF : 4'($urandom);
        case ($urandom_range(0, 2))
          0: mem_wdata = 32'h0;
          1: mem_wdata = 32'h1;
          default: mem_wdata = $urandom;
        endcase
        if ($urandom_range(0, 799) == 0) begin
          #2 rst = 1; #1 rst = 0;
        end
        @(negedge clk);
      end
    end
    idle_bus();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
